read_nand: RTL and testbench
============================

READ_NAND -- requirements
Module: read_nand

Interface
REQ-001 The module SHALL have parameter PACKET_LENGTH, default 1024, giving the data bytes read per page operation (legal range 1..4096).
REQ-002 The module SHALL have parameter ADDR_CYCLES, default 5, giving the address bytes issued (legal range 1..5).
REQ-003 The module SHALL have parameter TWB_CYCLES, default 8, giving the maximum wait for RnB_n to fall after the confirm command.
REQ-004 The module SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the busy-timeout limit (used only under REQ-030).
REQ-005 The module SHALL have these ports, one per line, clock and reset first:
- clock  input  1  single clock, all flops on rising edge
- reset  input  1  asynchronous, active-high
- start_read  input  1  one-cycle request, sampled in IDLE only
- addr_in  input  40  page/column address; byte 0 = addr_in[7:0], issued first
- RnB_n  input  1  NAND ready/busy; 0 = busy
- data_bus_in  input  8  NAND I/O, sampled during the data phase
- data_out  output  8  command/address byte driven to NAND
- data_oe  output  1  1 = controller drives the I/O bus
- cmd_latch  output  1  CLE
- addr_latch  output  1  ALE
- we_n  output  1  write enable, active-low
- re_n  output  1  read enable, active-low
- rd_data  output  8  captured byte to host
- rd_valid  output  1  rd_data valid
- rd_ready  input  1  host accepts rd_data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse on completion
- timeout_err  output  1  one-cycle pulse on busy timeout

Function
REQ-006 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-007 The FSM SHALL have exactly these states: IDLE, CMD1, ADDR, CMD2, WAIT_BUSY, WAIT_READY, RD_LOW, RD_HOLD, DONE.
REQ-008 In IDLE, start_read=1 SHALL latch addr_in, set busy=1 and enter CMD1 on the next edge.
REQ-009 The block SHALL ignore start_read in any state other than IDLE.
REQ-010 Each command or address byte SHALL take 2 cycles: cycle 1 we_n=0 and cycle 2 we_n=1, with data_out, data_oe and CLE/ALE held stable over both cycles.
REQ-011 CMD1 SHALL issue 8'h00 with cmd_latch=1.
REQ-012 ADDR SHALL issue ADDR_CYCLES bytes with addr_latch=1, using a 3-bit counter, then enter CMD2.
REQ-013 CMD2 SHALL issue 8'h30 with cmd_latch=1, then enter WAIT_BUSY with data_oe=0.
REQ-014 WAIT_BUSY SHALL enter WAIT_READY when RnB_n=0 or after TWB_CYCLES cycles, whichever comes first.
REQ-015 WAIT_READY SHALL enter RD_LOW on the first cycle RnB_n=1.
REQ-016 RD_LOW SHALL drive re_n=0 for one cycle, and the rising edge leaving RD_LOW SHALL capture data_bus_in into rd_data and set rd_valid=1.
REQ-017 In RD_HOLD, re_n SHALL be 1 and rd_valid SHALL hold until rd_valid&&rd_ready.
REQ-018 On the handshake in RD_HOLD, the block SHALL increment the 13-bit byte counter and enter RD_LOW, or DONE when the counter reaches PACKET_LENGTH.
REQ-019 rd_valid SHALL clear on the handshake edge, and rd_data SHALL NOT change while rd_valid=1.
REQ-020 DONE SHALL pulse done=1 for one cycle, clear busy and return to IDLE.
REQ-021 start_read in the DONE cycle SHALL be ignored.
REQ-022 If RnB_n=1 throughout WAIT_BUSY, WAIT_READY SHALL be entered after exactly TWB_CYCLES cycles.
REQ-023 data_oe SHALL be 0 in IDLE, WAIT_*, RD_* and DONE.

Reset
REQ-024 Asserting reset SHALL immediately force state=IDLE and all counters to 0.
REQ-025 Asserting reset SHALL immediately force cmd_latch=0, addr_latch=0, we_n=1, re_n=1, data_oe=0, data_out=8'h00, rd_data=8'h00, rd_valid=0, busy=0, done=0 and timeout_err=0.
REQ-026 Reset mid-operation SHALL abandon the transfer without emitting a done pulse.
REQ-027 The first start_read after reset deasserts SHALL be accepted normally.

Configuration
REQ-028 The macro READ_TIMEOUT_EN SHALL control the busy timeout.
REQ-029 When READ_TIMEOUT_EN is defined, a 16-bit counter SHALL run in WAIT_READY.
REQ-030 When READ_TIMEOUT_EN is defined and the counter reaches TIMEOUT_CYCLES while RnB_n=0, the block SHALL pulse timeout_err for one cycle, clear busy and enter IDLE without a done pulse.
REQ-031 When READ_TIMEOUT_EN is undefined, WAIT_READY SHALL wait indefinitely and timeout_err SHALL be tied to 0.

Verification
REQ-032 Basic read: PACKET_LENGTH=4, addr_in=40'h04_03_02_01_00, RnB_n low 20 cycles, rd_ready=1 -> bus sequence 00h(CLE), 00h,01h,02h,03h,04h(ALE), 30h(CLE); then 4 bytes out; one done pulse.
REQ-033 Back-pressure: rd_ready=0 for 10 cycles on byte 2 -> rd_valid held, rd_data stable, re_n=1, no extra re_n pulse.
REQ-034 Missed busy: RnB_n stays 1 -> data phase starts exactly TWB_CYCLES cycles after CMD2.
REQ-035 Reset mid-operation: reset asserted during the ADDR byte 3 -> all outputs at reset values in the same cycle, no done pulse, next start_read completes.
REQ-036 Timeout: READ_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, RnB_n held 0 -> one timeout_err pulse, busy=0, no done pulse.
REQ-037 Ignored restart: start_read pulsed during WAIT_READY and during DONE -> no restart and exactly one done pulse.

Source files
------------

// File: rtl/read_nand.sv
// NAND page-read controller: issues 00h / address / 30h, waits out tR, then streams bytes to the host.
// Optional busy timeout while waiting for ready is enabled by defining READ_TIMEOUT_EN.
module read_nand #(
   parameter int unsigned PACKET_LENGTH  = 1024,
   parameter int unsigned ADDR_CYCLES    = 5,
   parameter int unsigned TWB_CYCLES     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start_read,
   input  logic [39:0] addr_in,
   input  logic        RnB_n,
   input  logic [7:0]  data_bus_in,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic        cmd_latch,
   output logic        addr_latch,
   output logic        we_n,
   output logic        re_n,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic        busy,
   output logic        done,
   output logic        timeout_err
);

   localparam int unsigned CNT_W = 13;
   localparam int unsigned TWB_W = $clog2(TWB_CYCLES + 1);
   localparam int unsigned TO_W  = 16;
   localparam logic [7:0] CMD_READ    = 8'h00;
   localparam logic [7:0] CMD_CONFIRM = 8'h30;

   if (PACKET_LENGTH < 1 || PACKET_LENGTH > 4096 || ADDR_CYCLES < 1 || ADDR_CYCLES > 5 ||
       TWB_CYCLES < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
      $error("read_nand: parameter out of legal range");
   end

   typedef enum logic [3:0] {
      IDLE, CMD1, ADDR, CMD2, WAIT_BUSY, WAIT_READY, RD_LOW, RD_HOLD, DONE
   } state_t;

   state_t             state;
   logic [39:0]        addr_sr;
   logic [2:0]         addr_cnt;
   logic               we_phase;
   logic [TWB_W-1:0]   twb_cnt;
   logic [CNT_W-1:0]   byte_cnt;
`ifdef READ_TIMEOUT_EN
   logic [TO_W-1:0]    to_cnt;
`else
   assign timeout_err = 1'b0;
`endif

   // we_phase: 0 = strobe-low cycle of a bus write, 1 = hold cycle with we_n high
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         addr_sr    <= '0;
         addr_cnt   <= '0;
         we_phase   <= 1'b0;
         twb_cnt    <= '0;
         byte_cnt   <= '0;
         data_out   <= 8'h00;
         data_oe    <= 1'b0;
         cmd_latch  <= 1'b0;
         addr_latch <= 1'b0;
         we_n       <= 1'b1;
         re_n       <= 1'b1;
         rd_data    <= 8'h00;
         rd_valid   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
`ifdef READ_TIMEOUT_EN
         to_cnt      <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef READ_TIMEOUT_EN
         timeout_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (start_read) begin
                  addr_sr   <= addr_in;
                  byte_cnt  <= '0;
                  busy      <= 1'b1;
                  data_out  <= CMD_READ;
                  data_oe   <= 1'b1;
                  cmd_latch <= 1'b1;
                  we_n      <= 1'b0;
                  we_phase  <= 1'b0;
                  state     <= CMD1;
               end
            end
            CMD1: begin
               if (!we_phase) begin
                  we_n     <= 1'b1;
                  we_phase <= 1'b1;
               end else begin
                  cmd_latch  <= 1'b0;
                  addr_latch <= 1'b1;
                  data_out   <= addr_sr[7:0];
                  addr_sr    <= addr_sr >> 8;
                  addr_cnt   <= '0;
                  we_n       <= 1'b0;
                  we_phase   <= 1'b0;
                  state      <= ADDR;
               end
            end
            ADDR: begin
               if (!we_phase) begin
                  we_n     <= 1'b1;
                  we_phase <= 1'b1;
               end else if (addr_cnt == 3'(ADDR_CYCLES - 1)) begin
                  addr_latch <= 1'b0;
                  cmd_latch  <= 1'b1;
                  data_out   <= CMD_CONFIRM;
                  we_n       <= 1'b0;
                  we_phase   <= 1'b0;
                  state      <= CMD2;
               end else begin
                  addr_cnt <= addr_cnt + 3'd1;
                  data_out <= addr_sr[7:0];
                  addr_sr  <= addr_sr >> 8;
                  we_n     <= 1'b0;
                  we_phase <= 1'b0;
               end
            end
            CMD2: begin
               if (!we_phase) begin
                  we_n     <= 1'b1;
                  we_phase <= 1'b1;
               end else begin
                  cmd_latch <= 1'b0;
                  data_oe   <= 1'b0;
                  data_out  <= 8'h00;
                  twb_cnt   <= '0;
                  state     <= WAIT_BUSY;
               end
            end
            // A missed busy edge falls through after TWB_CYCLES cycles
            WAIT_BUSY: begin
               if (!RnB_n || twb_cnt == TWB_W'(TWB_CYCLES - 1)) begin
                  state <= WAIT_READY;
`ifdef READ_TIMEOUT_EN
                  to_cnt <= '0;
`endif
               end else begin
                  twb_cnt <= twb_cnt + TWB_W'(1);
               end
            end
            WAIT_READY: begin
               if (RnB_n) begin
                  re_n  <= 1'b0;
                  state <= RD_LOW;
               end
`ifdef READ_TIMEOUT_EN
               else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
`endif
            end
            RD_LOW: begin
               re_n     <= 1'b1;
               rd_data  <= data_bus_in;
               rd_valid <= 1'b1;
               state    <= RD_HOLD;
            end
            RD_HOLD: begin
               if (rd_valid && rd_ready) begin
                  rd_valid <= 1'b0;
                  byte_cnt <= byte_cnt + CNT_W'(1);
                  if (CNT_W'(byte_cnt + CNT_W'(1)) == CNT_W'(PACKET_LENGTH)) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= DONE;
                  end else begin
                     re_n  <= 1'b0;
                     state <= RD_LOW;
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_read_nand.sv
// Self-checking bench for read_nand: NAND/host models plus a per-cycle scoreboard.
// Build with READ_TIMEOUT_EN defined to exercise the busy timeout.
module tb_read_nand;

   localparam int unsigned PKT  = 4;
   localparam int unsigned ACYC = 5;
   localparam int unsigned TWB  = 8;
   localparam int unsigned TO   = 100;
   localparam logic [24:0] RST_OUTS = {2'b00, 2'b11, 1'b0, 8'h00, 8'h00, 4'b0000};

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start_read = 1'b0;
   logic [39:0] addr_in = '0;
   logic        RnB_n = 1'b1;
   logic [7:0]  data_bus_in = 8'h00;
   logic        rd_ready = 1'b1;
   logic [7:0]  data_out, rd_data;
   logic        data_oe, cmd_latch, addr_latch, we_n, re_n, rd_valid, busy, done, timeout_err;

   read_nand #(.PACKET_LENGTH(PKT), .ADDR_CYCLES(ACYC), .TWB_CYCLES(TWB), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset), .start_read(start_read), .addr_in(addr_in), .RnB_n(RnB_n),
      .data_bus_in(data_bus_in), .data_out(data_out), .data_oe(data_oe), .cmd_latch(cmd_latch),
      .addr_latch(addr_latch), .we_n(we_n), .re_n(re_n), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_ready(rd_ready), .busy(busy), .done(done), .timeout_err(timeout_err));

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [24:0] outs();
      return {cmd_latch, addr_latch, we_n, re_n, data_oe, data_out, rd_data, rd_valid, busy, done, timeout_err};
   endfunction

   // Model state: expected bus writes {cle,ale,byte}, expected host bytes, NAND/host behaviour
   logic [9:0]  exp_bus[$];
   logic [7:0]  exp_rd[$];
   logic [7:0]  got_rd[$];
   int exp_done = 0, done_cnt = 0, to_cnt = 0;
   int busy_len = 0, nand_busy = 0, nand_idx = 0;
   logic [7:0] nand_base = 8'h00;
   int stall_byte = -1, stall_left = 0, hs_idx = 0;
   int cyc = 0, oe_fall_cyc = 0, re_gap = -1, valid_run = 0, max_run = 0;
   bit re_seen, prev_we_low, prev_re_low, prev_done, prev_oe, prev_hold;
   logic [10:0] held_bus;
   logic [7:0]  held_rd;
   logic [9:0]  e;

   always @(negedge clock) begin
      cyc++;
      if (reset) begin
         prev_we_low = 0; prev_re_low = 0; prev_done = 0; prev_oe = 0; prev_hold = 0;
         nand_busy = 0; RnB_n = 1'b1; rd_ready = 1'b1; valid_run = 0;
      end else begin
         // NAND: busy_len cycles of RnB_n low after the confirm command; byte per re_n pulse
         if (!we_n && cmd_latch && data_out == 8'h30) nand_busy = busy_len;
         else if (nand_busy > 0) nand_busy--;
         RnB_n = (nand_busy == 0);
         if (!re_n) begin
            data_bus_in = nand_base + 8'(nand_idx);
            nand_idx++;
         end
         // Host: optional stall on one byte
         if (rd_valid && hs_idx == stall_byte && stall_left > 0) begin
            rd_ready = 1'b0;
            stall_left--;
         end else rd_ready = 1'b1;
         // Bus writes: one strobe-low cycle, then an identical hold cycle
         if (!we_n) begin
            chk("we_n_width", 40'(prev_we_low), 40'd0);
            chk("busy_during_op", 40'(busy), 40'd1);
            if (exp_bus.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_bus_write: got %0h expected none", data_out);
            end else begin
               e = exp_bus.pop_front();
               chk("bus_byte", 40'({data_oe, cmd_latch, addr_latch, data_out}), 40'({1'b1, e}));
            end
            held_bus = {data_oe, cmd_latch, addr_latch, data_out};
            prev_we_low = 1;
         end else begin
            if (prev_we_low) chk("bus_hold", 40'({data_oe, cmd_latch, addr_latch, data_out}), 40'(held_bus));
            prev_we_low = 0;
         end
         chk("oe_vs_latches", 40'(data_oe), 40'(cmd_latch | addr_latch));
         if (prev_oe && !data_oe) begin oe_fall_cyc = cyc; re_seen = 0; end
         prev_oe = data_oe;
         if (!re_n) begin
            if (!re_seen) begin re_gap = cyc - oe_fall_cyc; re_seen = 1; end
            chk("re_n_one_cycle", 40'(prev_re_low), 40'd0);
            chk("re_n_while_valid", 40'(rd_valid), 40'd0);
         end
         prev_re_low = !re_n;
         // Host side: data must be steady while held, correct when taken
         if (rd_valid) begin
            if (prev_hold) chk("rd_data_stable", 40'(rd_data), 40'(held_rd));
            valid_run++;
            if (rd_ready) begin
               if (exp_rd.size() == 0) begin
                  n_chk++;
                  $display("FAIL unexpected_rd_byte: got %0h expected none", rd_data);
               end else chk("rd_byte", 40'(rd_data), 40'(exp_rd.pop_front()));
               got_rd.push_back(rd_data);
               hs_idx++;
               if (valid_run > max_run) max_run = valid_run;
               valid_run = 0;
               prev_hold = 0;
            end else begin
               prev_hold = 1;
               held_rd = rd_data;
            end
         end else prev_hold = 0;
         if (done) begin
            chk("done_one_cycle", 40'(prev_done), 40'd0);
            chk("busy_low_at_done", 40'(busy), 40'd0);
            done_cnt++;
         end
         prev_done = done;
         if (timeout_err) to_cnt++;
      end
   end

   task automatic start_op(input logic [39:0] a, input int blen, input logic [7:0] base,
                           input int sb, input int sn, input bit expect_done);
      exp_bus.push_back({1'b1, 1'b0, 8'h00});
      for (int i = 0; i < int'(ACYC); i++) exp_bus.push_back({1'b0, 1'b1, a[8*i +: 8]});
      exp_bus.push_back({1'b1, 1'b0, 8'h30});
      if (expect_done) begin
         for (int i = 0; i < int'(PKT); i++) exp_rd.push_back(base + 8'(i));
         exp_done++;
      end
      busy_len = blen; nand_base = base; nand_idx = 0;
      stall_byte = sb; stall_left = sn; hs_idx = 0; max_run = 0;
      got_rd.delete();
      @(negedge clock);
      start_read = 1'b1;
      addr_in = a;
      @(negedge clock);
      start_read = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 2000 && done_cnt < exp_done; i++) @(negedge clock);
      chk(name, 40'(done_cnt), 40'(exp_done));
      chk("bus_drained", 40'(exp_bus.size()), 40'd0);
      chk("rd_drained", 40'(exp_rd.size()), 40'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cnt;
      repeat (3) @(negedge clock);
      chk("reset_outputs", 40'(outs()), 40'(RST_OUTS));
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // Basic read, RnB_n low for 20 cycles
      start_op(40'h04_03_02_01_00, 20, 8'hA0, -1, 0, 1);
      wait_done("basic_done");
      chk("basic_bytes", 40'({got_rd[0], got_rd[1], got_rd[2], got_rd[3]}), 40'h00A0A1A2A3);
      chk("basic_done_count", 40'(done_cnt), 40'd1);

      // Back-pressure: byte 2 held 10 extra cycles
      start_op(40'h11_22_33_44_55, 5, 8'h50, 1, 10, 1);
      wait_done("bp_done");
      chk("bp_valid_cycles", 40'(max_run), 40'd11);
      chk("bp_bytes", 40'({got_rd[0], got_rd[1], got_rd[2], got_rd[3]}), 40'h0050515253);

      // Missed busy: 8 WAIT_BUSY cycles + 1 WAIT_READY cycle before re_n falls
      start_op(40'h0A_0B_0C_0D_0E, 0, 8'h10, -1, 0, 1);
      wait_done("missed_busy_done");
      chk("missed_busy_gap", 40'(re_gap), 40'd9);

      // Reset during the third address byte
      start_op(40'hC1_C2_C3_C4_C5, 10, 8'h20, -1, 0, 0);
      cnt = 0;
      for (int i = 0; i < 100 && cnt < 3; i++) begin
         @(negedge clock);
         if (!we_n && addr_latch) cnt++;
      end
      chk("addr_byte3_reached", 40'(cnt), 40'd3);
      reset = 1'b1;
      #1;
      chk("reset_async_outputs", 40'(outs()), 40'(RST_OUTS));
      @(negedge clock);
      reset = 1'b0;
      exp_bus.delete();
      exp_rd.delete();
      repeat (5) @(negedge clock);
      chk("no_done_after_reset", 40'(done_cnt), 40'(exp_done));
      chk("idle_after_reset", 40'(outs()), 40'(RST_OUTS));
      start_op(40'h99_88_77_66_55, 3, 8'h30, -1, 0, 1);
      wait_done("after_reset_done");

      // start_read ignored in WAIT_READY and in DONE
      start_op(40'h55_66_77_88_99, 30, 8'h70, -1, 0, 1);
      for (int i = 0; i < 100 && exp_bus.size() != 0; i++) @(negedge clock);
      repeat (6) @(negedge clock);
      chk("in_wait_ready", 40'({busy, RnB_n, data_oe, re_n}), 40'b1001);
      start_read = 1'b1;
      addr_in = 40'hFF_FF_FF_FF_FF;
      @(negedge clock);
      start_read = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clock);
         if (done) begin
            start_read = 1'b1;
            @(negedge clock);
            start_read = 1'b0;
            break;
         end
      end
      repeat (30) @(negedge clock);
      chk("restart_done_count", 40'(done_cnt), 40'(exp_done));
      chk("restart_idle_busy", 40'(busy), 40'd0);
      chk("restart_no_bus", 40'(exp_bus.size()), 40'd0);

`ifdef READ_TIMEOUT_EN
      start_op(40'h01_02_03_04_05, 1000000, 8'h00, -1, 0, 0);
      for (int i = 0; i < 400 && to_cnt == 0; i++) @(negedge clock);
      chk("timeout_pulse", 40'(to_cnt), 40'd1);
      chk("timeout_busy_cleared", 40'(busy), 40'd0);
      repeat (10) @(negedge clock);
      chk("timeout_single_pulse", 40'(to_cnt), 40'd1);
      chk("timeout_no_done", 40'(done_cnt), 40'(exp_done));
`else
      chk("timeout_never", 40'(to_cnt), 40'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
